// File: rtl/izh_fixed_pkg.sv
// Shared number format, FSM state encoding and sign-magnitude helpers for the
// Izhikevich update datapath (17-bit sign-magnitude, Q9.7 magnitude).
package izh_fixed_pkg;

  localparam int SM_W   = 17;
  localparam int MAG_W  = 16;
  localparam int FRAC_W = 7;
  localparam int ACC_W  = 19;
  // Six-term sums are accumulated with three guard bits so they never wrap
  // before the single final saturation.
  localparam int SUM_W  = ACC_W + 3;

  localparam logic [SM_W-1:0] K_SQ_DEF     = 17'h0001A;
  localparam logic [SM_W-1:0] C_FIVE_DEF   = 17'h00280;
  localparam logic [SM_W-1:0] C_140_DEF    = 17'h04600;
  localparam logic [SM_W-1:0] V_THRESH_DEF = 17'h00F00;

  typedef enum logic [2:0] {
    S_IDLE, S_M_KV, S_M_WW, S_M_5V, S_M_BV, S_M_AW, S_SUM, S_DONE
  } state_t;

  typedef struct packed {
    logic            ovf;
    logic [SM_W-1:0] val;
  } sat_t;

  function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [SM_W-1:0] x);
    logic signed [ACC_W-1:0] m;
    m = signed'({{(ACC_W-MAG_W){1'b0}}, x[MAG_W-1:0]});
    return x[SM_W-1] ? -m : m;
  endfunction

  // Saturate a two's complement value to sign-magnitude; zero is always +0.
  function automatic sat_t tc_to_sm_sat(input logic signed [SUM_W-1:0] x);
    sat_t             r;
    logic [SUM_W-1:0] mag;
    mag = x[SUM_W-1] ? unsigned'(-x) : unsigned'(x);
    r.ovf = |mag[SUM_W-1:MAG_W];
    r.val[MAG_W-1:0] = r.ovf ? {MAG_W{1'b1}} : mag[MAG_W-1:0];
    r.val[SM_W-1] = x[SUM_W-1];
    return r;
  endfunction

  // Saturating sign-magnitude subtract a - b.
  function automatic logic [SM_W-1:0] sm_sub_sat(input logic [SM_W-1:0] a,
                                                 input logic [SM_W-1:0] b);
    logic signed [SUM_W-1:0] d;
    logic [SUM_W-1:0]        mag;
    logic [SM_W-1:0]         r;
    d   = SUM_W'(sm_to_tc(a)) - SUM_W'(sm_to_tc(b));
    mag = d[SUM_W-1] ? unsigned'(-d) : unsigned'(d);
    r[MAG_W-1:0] = (|mag[SUM_W-1:MAG_W]) ? {MAG_W{1'b1}} : mag[MAG_W-1:0];
    r[SM_W-1] = d[SUM_W-1];
    return r;
  endfunction

endpackage

// File: rtl/izh_neuron_update_fixed_mult.sv
// Combinational sign-magnitude Q9.7 multiplier: truncates the fraction and
// saturates the magnitude, flagging integer overflow and lost fraction bits.
module fixed_mult
  import izh_fixed_pkg::*;
(
  input  logic [SM_W-1:0] i_a,
  input  logic [SM_W-1:0] i_b,
  output logic [SM_W-1:0] o_p,
  output logic            o_clip_int,
  output logic            o_clip_frac
);

  logic [2*MAG_W-1:0] w_full;
  logic [MAG_W-1:0]   w_mag;

  assign w_full      = {{MAG_W{1'b0}}, i_a[MAG_W-1:0]} * {{MAG_W{1'b0}}, i_b[MAG_W-1:0]};
  assign o_clip_int  = |w_full[2*MAG_W-1:MAG_W+FRAC_W];
  assign o_clip_frac = |w_full[FRAC_W-1:0];
  assign w_mag       = o_clip_int ? {MAG_W{1'b1}} : w_full[MAG_W+FRAC_W-1:FRAC_W];
  assign o_p         = {(i_a[SM_W-1] ^ i_b[SM_W-1]) & (|w_mag), w_mag};

endmodule

// File: rtl/izh_neuron_update.sv
// Sequential Izhikevich neuron update: one shared multiplier is stepped over
// five products, then v' and u' are summed, saturated and spike-tested.
module izh_neuron_update
  import izh_fixed_pkg::*;
#(
  parameter logic [SM_W-1:0] V_THRESH = V_THRESH_DEF,
  parameter logic [SM_W-1:0] K_SQ     = K_SQ_DEF,
  parameter logic [SM_W-1:0] C_FIVE   = C_FIVE_DEF,
  parameter logic [SM_W-1:0] C_140    = C_140_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SM_W-1:0] v_in,
  input  logic [SM_W-1:0] u_in,
  input  logic [SM_W-1:0] i_in,
  input  logic [SM_W-1:0] a,
  input  logic [SM_W-1:0] b,
  input  logic [SM_W-1:0] c,
  input  logic [SM_W-1:0] d,
  output logic            busy,
  output logic            done,
  output logic [SM_W-1:0] v_out,
  output logic [SM_W-1:0] u_out,
  output logic            spike,
  output logic            clip
);

  state_t          r_state;
  logic [SM_W-1:0] r_v, r_u, r_i, r_a, r_b, r_c, r_d;
  logic [SM_W-1:0] r_w, r_w2, r_v5, r_bv, r_du;

  logic [SM_W-1:0]         w_ma, w_mb, w_p;
  logic                    w_clip_int, w_clip_frac_unused;
  logic signed [SUM_W-1:0] w_vn_acc, w_un_acc, w_ud_acc;
  sat_t                    w_vn_s, w_un_s, w_ud_s;
  logic                    w_spike;

  function automatic logic signed [SUM_W-1:0] ext(input logic [SM_W-1:0] x);
    return SUM_W'(sm_to_tc(x));
  endfunction

  fixed_mult u_mult (
    .i_a         (w_ma),
    .i_b         (w_mb),
    .o_p         (w_p),
    .o_clip_int  (w_clip_int),
    .o_clip_frac (w_clip_frac_unused)
  );

  // Operand mux: select the multiplier inputs for the current product state.
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    case (r_state)
      S_M_KV: begin w_ma = K_SQ;   w_mb = r_v; end
      S_M_WW: begin w_ma = r_w;    w_mb = r_w; end
      S_M_5V: begin w_ma = C_FIVE; w_mb = r_v; end
      S_M_BV: begin w_ma = r_b;    w_mb = r_v; end
      S_M_AW: begin w_ma = r_a;    w_mb = sm_sub_sat(r_bv, r_u); end
      default: ;
    endcase
  end

  // SUM stage: exact two's complement sums, each saturated once, then spike test.
  always_comb begin
    w_vn_acc = ext(r_v) + ext(r_w2) + ext(r_v5) + ext(C_140) - ext(r_u) + ext(r_i);
    w_un_acc = ext(r_u) + ext(r_du);
    w_ud_acc = w_un_acc + ext(r_d);
    w_vn_s   = tc_to_sm_sat(w_vn_acc);
    w_un_s   = tc_to_sm_sat(w_un_acc);
    w_ud_s   = tc_to_sm_sat(w_ud_acc);
    w_spike  = !w_vn_s.val[SM_W-1] && (w_vn_s.val[MAG_W-1:0] >= V_THRESH[MAG_W-1:0]);
  end

  // Control FSM and datapath registers, one cycle per state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      spike <= 1'b0;
      clip  <= 1'b0;
      v_out <= '0;
      u_out <= '0;
      r_v <= '0; r_u <= '0; r_i <= '0; r_a <= '0; r_b <= '0; r_c <= '0; r_d <= '0;
      r_w <= '0; r_w2 <= '0; r_v5 <= '0; r_bv <= '0; r_du <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_v <= v_in; r_u <= u_in; r_i <= i_in;
            r_a <= a; r_b <= b; r_c <= c; r_d <= d;
            clip    <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_M_KV;
          end
        end
        S_M_KV: begin r_w  <= w_p; clip <= clip | w_clip_int; r_state <= S_M_WW; end
        S_M_WW: begin r_w2 <= w_p; clip <= clip | w_clip_int; r_state <= S_M_5V; end
        S_M_5V: begin r_v5 <= w_p; clip <= clip | w_clip_int; r_state <= S_M_BV; end
        S_M_BV: begin r_bv <= w_p; clip <= clip | w_clip_int; r_state <= S_M_AW; end
        S_M_AW: begin r_du <= w_p; clip <= clip | w_clip_int; r_state <= S_SUM;  end
        S_SUM: begin
          spike <= w_spike;
          if (w_spike) begin
            v_out <= r_c;
            u_out <= w_ud_s.val;
            clip  <= clip | w_vn_s.ovf | w_ud_s.ovf;
          end else begin
            v_out <= w_vn_s.val;
            u_out <= w_un_s.val;
            clip  <= clip | w_vn_s.ovf | w_un_s.ovf;
          end
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_izh_neuron_update.sv
// Scoreboard bench for izh_neuron_update: directed vectors push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_izh_neuron_update;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [16:0] v_in, u_in, i_in, a, b, c, d;
  logic        busy, done, spike, clip;
  logic [16:0] v_out, u_out;

  izh_neuron_update dut (
    .clk(clk), .rst(rst), .start(start),
    .v_in(v_in), .u_in(u_in), .i_in(i_in),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .v_out(v_out), .u_out(u_out),
    .spike(spike), .clip(clip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] v;
    logic [16:0] u;
    logic        s;
    logic        c;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pop and compare whenever the DUT signals done.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("done_pulse_width", {31'b0, prev_done}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done v_out=%h", v_out);
      end else begin
        e = q.pop_front();
        chk("v_out", {15'b0, v_out}, {15'b0, e.v});
        chk("u_out", {15'b0, u_out}, {15'b0, e.u});
        chk("spike", {31'b0, spike}, {31'b0, e.s});
        chk("clip",  {31'b0, clip},  {31'b0, e.c});
      end
    end
    prev_done = done;
  end

  task automatic drive(input logic [16:0] v, input logic [16:0] u, input logic [16:0] i);
    v_in = v; u_in = u; i_in = i;
  endtask

  task automatic update(input logic [16:0] v, input logic [16:0] u, input logic [16:0] i,
                        input logic [16:0] ev, input logic [16:0] eu,
                        input logic es, input logic ec);
    int lat;
    lat = 0;
    @(negedge clk);
    drive(v, u, i);
    start = 1'b1;
    q.push_back('{v: ev, u: eu, s: es, c: ec});
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
      end
      if (done) lat = k;
    end
    chk("latency", lat, 32'd7);
    @(negedge clk);
    chk("busy_back_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, k, base;
    rst = 1'b1; start = 1'b0;
    a = 17'h00003; b = 17'h0001A; c = 17'h12080; d = 17'h00400;
    drive(17'h0, 17'h0, 17'h0);
    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'b0, busy},  32'd0);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_spike", {31'b0, spike}, 32'd0);
    chk("rst_clip",  {31'b0, clip},  32'd0);
    chk("rst_v_out", {15'b0, v_out}, 32'd0);
    chk("rst_u_out", {15'b0, u_out}, 32'd0);
    rst = 1'b0;

    // Directed vectors
    update(17'h12000, 17'h10680, 17'h00000, 17'h11F00, 17'h10680, 1'b0, 1'b0);
    update(17'h00000, 17'h00000, 17'h00000, 17'h12080, 17'h00400, 1'b1, 1'b0);
    update(17'h00000, 17'h00000, 17'h13700, 17'h12080, 17'h00400, 1'b1, 1'b0);
    update(17'h00000, 17'h00000, 17'h13701, 17'h00EFF, 17'h00000, 1'b0, 1'b0);
    update(17'h00000, 17'h00000, 17'h0C800, 17'h12080, 17'h00400, 1'b1, 1'b1);
    update(17'h00000, 17'h00000, 17'h14600, 17'h00000, 17'h00000, 1'b0, 1'b0);
    update(17'h00000, 17'h00400, 17'h00000, 17'h12080, 17'h007E8, 1'b1, 1'b0);
    update(17'h0FFFF, 17'h00000, 17'h00000, 17'h12080, 17'h00537, 1'b1, 1'b1);

    // Start held high: one update per IDLE visit, eight cycles apart
    @(negedge clk);
    drive(17'h12000, 17'h10680, 17'h00000);
    start = 1'b1;
    q.push_back('{v: 17'h11F00, u: 17'h10680, s: 1'b0, c: 1'b0});
    q.push_back('{v: 17'h11F00, u: 17'h10680, s: 1'b0, c: 1'b0});
    base = done_cnt;
    n = 0; k = 0;
    while (n < 2 && k < 40) begin
      @(negedge clk);
      k++;
      if (done) n++;
    end
    start = 1'b0;
    chk("held_done_count", n, 32'd2);
    chk("held_second_done_cycle", k, 32'd15);
    repeat (4) @(negedge clk);
    chk("held_no_extra_done", done_cnt - base, 32'd2);
    chk("held_busy_idle", {31'b0, busy}, 32'd0);

    // Start during busy is ignored; latched inputs are used
    @(negedge clk);
    drive(17'h12000, 17'h10680, 17'h00000);
    start = 1'b1;
    q.push_back('{v: 17'h11F00, u: 17'h10680, s: 1'b0, c: 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    drive(17'h00000, 17'h00000, 17'h00000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = done_cnt;
    repeat (12) @(negedge clk);
    chk("busy_start_one_done", done_cnt - base, 32'd1);
    chk("busy_start_idle", {31'b0, busy}, 32'd0);

    // Reset in M_BV aborts the update with no done
    @(negedge clk);
    drive(17'h00000, 17'h00000, 17'h00000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    base = done_cnt;
    @(negedge clk);
    chk("abort_busy",  {31'b0, busy},  32'd0);
    chk("abort_done",  {31'b0, done},  32'd0);
    chk("abort_v_out", {15'b0, v_out}, 32'd0);
    chk("abort_u_out", {15'b0, u_out}, 32'd0);
    chk("abort_spike", {31'b0, spike}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt - base, 32'd0);

    update(17'h00000, 17'h00000, 17'h00000, 17'h12080, 17'h00400, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
